// File: rtl/iserdes_align_ctrl.sv
//------------------------------------------------------------------------------
// Module  : iserdes_align_ctrl
// Brief   : Scans the DCO IDELAY eye and parks the delay at the centre of the
//           widest stable window. It then bitslips until the training word lines up.
//           Define ISERDES_ALIGN_EYE_MAP_EN to add the eye_map output.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module iserdes_align_ctrl #(
  parameter logic [7:0] PATTERN    = 8'h0F,
  parameter int         SETTLE     = 16,
  parameter int         CHECK_LEN  = 64,
  parameter int         MIN_WINDOW = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [7:0]  data_in,
  input  logic [4:0]  id_value,
  output logic        id_inc,
  output logic        id_dec,
  output logic        bitslip,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  locked_tap,
  output logic [2:0]  slip_count
`ifdef ISERDES_ALIGN_EYE_MAP_EN
  ,
  output logic [31:0] eye_map
`endif
);

  localparam int CNT_W = $clog2((SETTLE > CHECK_LEN) ? SETTLE : CHECK_LEN) + 1;
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] c_check_last  = CNT_W'(CHECK_LEN - 1);

  localparam logic [3:0] c_idle        = 4'd0;
  localparam logic [3:0] c_zero        = 4'd1;
  localparam logic [3:0] c_zero_dec    = 4'd2;
  localparam logic [3:0] c_zero_settle = 4'd3;
  localparam logic [3:0] c_scan_samp   = 4'd4;
  localparam logic [3:0] c_scan_inc    = 4'd5;
  localparam logic [3:0] c_scan_settle = 4'd6;
  localparam logic [3:0] c_center      = 4'd7;
  localparam logic [3:0] c_ctr_check   = 4'd8;
  localparam logic [3:0] c_ctr_dec     = 4'd9;
  localparam logic [3:0] c_ctr_settle  = 4'd10;
  localparam logic [3:0] c_slip_samp   = 4'd11;
  localparam logic [3:0] c_slip_pulse  = 4'd12;
  localparam logic [3:0] c_slip_settle = 4'd13;
  localparam logic [3:0] c_done        = 4'd14;
  localparam logic [3:0] c_fail        = 4'd15;

  logic [3:0]       r_state;
  logic [3:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_first;
  logic             r_ok;
  logic [4:0]       r_cur_start;
  logic [5:0]       r_cur_len;
  logic [4:0]       r_best_start;
  logic [5:0]       r_best_len;
  logic [4:0]       r_target;
  logic [4:0]       r_locked_tap;
  logic [2:0]       r_slip_count;
  logic [31:0]      r_eye_map;

  function automatic logic is_rotation(input logic [7:0] w);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (w == 8'({PATTERN, PATTERN} >> i)) hit = 1'b1;
    end
    return hit;
  endfunction

  logic       w_start_ok;
  logic       w_settled;
  logic       w_last;
  logic       w_scan_good;
  logic       w_slip_good;
  logic [5:0] w_cur_len_inc;

  assign w_start_ok    = start && (r_state == c_idle || r_state == c_done || r_state == c_fail);
  assign w_settled     = (r_cnt == c_settle_last);
  assign w_last        = (r_cnt == c_check_last);
  // Each running flag covers samples 1..n-1; the final sample is folded in here.
  assign w_scan_good   = r_ok && (data_in == r_first) && is_rotation(r_first);
  assign w_slip_good   = r_ok && (data_in == PATTERN);
  assign w_cur_len_inc = r_cur_len + 6'd1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= c_idle;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle, c_done, c_fail: if (w_start_ok) w_state_nxt = c_zero;
      c_zero:        w_state_nxt = (id_value != 5'd0) ? c_zero_dec : c_scan_samp;
      c_zero_dec:    w_state_nxt = c_zero_settle;
      c_zero_settle: if (w_settled) w_state_nxt = c_zero;
      c_scan_samp:   if (w_last) w_state_nxt = (id_value == 5'd31) ? c_center : c_scan_inc;
      c_scan_inc:    w_state_nxt = c_scan_settle;
      c_scan_settle: if (w_settled) w_state_nxt = c_scan_samp;
      c_center:      w_state_nxt = (r_best_len < 6'(MIN_WINDOW)) ? c_fail : c_ctr_check;
      c_ctr_check:   w_state_nxt = (id_value == r_target) ? c_slip_samp : c_ctr_dec;
      c_ctr_dec:     w_state_nxt = c_ctr_settle;
      c_ctr_settle:  if (w_settled) w_state_nxt = c_ctr_check;
      c_slip_samp: begin
        if (w_last) begin
          if (w_slip_good)                w_state_nxt = c_done;
          else if (r_slip_count == 3'd7)  w_state_nxt = c_fail;
          else                            w_state_nxt = c_slip_pulse;
        end
      end
      c_slip_pulse:  w_state_nxt = c_slip_settle;
      c_slip_settle: if (w_settled) w_state_nxt = c_slip_samp;
      default:       w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    id_inc  = 1'b0;
    id_dec  = 1'b0;
    bitslip = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    error   = 1'b0;
    case (r_state)
      c_idle:                 busy    = 1'b0;
      c_done:       begin     busy    = 1'b0; done  = 1'b1; end
      c_fail:       begin     busy    = 1'b0; error = 1'b1; end
      c_zero_dec, c_ctr_dec:  id_dec  = 1'b1;
      c_scan_inc:             id_inc  = 1'b1;
      c_slip_pulse:           bitslip = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt        <= '0;
      r_first      <= '0;
      r_ok         <= 1'b0;
      r_cur_start  <= '0;
      r_cur_len    <= '0;
      r_best_start <= '0;
      r_best_len   <= '0;
      r_target     <= '0;
      r_locked_tap <= '0;
      r_slip_count <= '0;
      r_eye_map    <= '0;
    end else begin
      if (!busy || w_state_nxt != r_state) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + 1'b1;

      if (r_state == c_scan_samp || r_state == c_slip_samp) begin
        if (r_cnt == '0) begin
          r_first <= data_in;
          r_ok    <= (r_state == c_scan_samp) || (data_in == PATTERN);
        end else begin
          r_ok    <= r_ok && (data_in == ((r_state == c_scan_samp) ? r_first : PATTERN));
        end
      end

      if (w_start_ok) begin
        r_slip_count <= '0;
        r_cur_start  <= '0;
        r_cur_len    <= '0;
        r_best_start <= '0;
        r_best_len   <= '0;
        r_eye_map    <= '0;
      end

      // Strictly-greater update keeps the lower window on a tie.
      if (r_state == c_scan_samp && w_last) begin
        if (w_scan_good) begin
          r_cur_len <= w_cur_len_inc;
          r_eye_map[id_value] <= 1'b1;
          if (r_cur_len == '0) r_cur_start <= id_value;
          if (w_cur_len_inc > r_best_len) begin
            r_best_len   <= w_cur_len_inc;
            r_best_start <= (r_cur_len == '0) ? id_value : r_cur_start;
          end
        end else begin
          r_cur_len <= '0;
        end
      end

      if (r_state == c_center)
        r_target <= r_best_start + 5'((r_best_len - 6'd1) >> 1);
      if (r_state == c_ctr_check && id_value == r_target)
        r_locked_tap <= r_target;
      if (r_state == c_slip_pulse)
        r_slip_count <= r_slip_count + 3'd1;
    end
  end

  assign locked_tap = r_locked_tap;
  assign slip_count = r_slip_count;

`ifdef ISERDES_ALIGN_EYE_MAP_EN
  assign eye_map = r_eye_map;
`else
  logic w_eye_map_unused;
  assign w_eye_map_unused = ^r_eye_map;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iserdes_align_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_iserdes_align_ctrl
// Brief   : Bench for iserdes_align_ctrl with an IDELAY/ISERDES environment model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iserdes_align_ctrl;

  localparam logic [7:0] PAT = 8'h0F;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start   = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [4:0]  id_value;
  logic        id_inc, id_dec, bitslip, busy, done, error;
  logic [4:0]  locked_tap;
  logic [2:0]  slip_count;
`ifdef ISERDES_ALIGN_EYE_MAP_EN
  logic [31:0] eye_map;
`endif

  iserdes_align_ctrl dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .data_in    (data_in),
    .id_value   (id_value),
    .id_inc     (id_inc),
    .id_dec     (id_dec),
    .bitslip    (bitslip),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .locked_tap (locked_tap),
    .slip_count (slip_count)
`ifdef ISERDES_ALIGN_EYE_MAP_EN
    ,
    .eye_map    (eye_map)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Environment: tap counter, good-tap map and the bitslip-rotated training word.
  bit good[32];
  int tap = 0;
  int off = 0;
  bit zero_mode = 1'b0;
  bit seen_inc, seen31, post_dec;
  int n_dec_pre, n_dec_mid, n_dec_post, n_inc, n_slip, n_overlap;
  int exp_locked = 0;

  assign id_value = tap[4:0];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  always @(negedge sys_clk) begin
    if (int'(id_inc) + int'(id_dec) + int'(bitslip) > 1) n_overlap++;
    if (id_inc) begin
      n_inc++;
      seen_inc = 1'b1;
      tap = (tap + 1) & 31;
    end
    if (id_dec) begin
      if (seen31) begin
        n_dec_post++;
        post_dec = 1'b1;
      end else if (seen_inc) n_dec_mid++;
      else n_dec_pre++;
      tap = (tap + 31) & 31;
    end
    if (bitslip) n_slip++;
    if (tap == 31) seen31 = 1'b1;
    if (good[tap])
      data_in = (zero_mode && post_dec) ? 8'h00 : rotl8(PAT, (((off - n_slip) % 8) + 8) % 8);
    else
      data_in = 8'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_env();
    seen_inc = 0; seen31 = 0; post_dec = 0;
    n_dec_pre = 0; n_dec_mid = 0; n_dec_post = 0;
    n_inc = 0; n_slip = 0; n_overlap = 0;
  endtask

  task automatic set_eye(input int lo, input int hi);
    for (int t = lo; t <= hi && t < 32; t++) good[t] = 1'b1;
  endtask

  task automatic clear_eye();
    for (int t = 0; t < 32; t++) good[t] = 1'b0;
  endtask

  // Reference: longest run of good taps, first one wins a tie.
  task automatic model(output int bs, output int bl);
    int run;
    bs = 0; bl = 0; run = 0;
    for (int t = 0; t < 32; t++) begin
      if (good[t]) begin
        run++;
        if (run > bl) begin bl = run; bs = t - run + 1; end
      end else run = 0;
    end
  endtask

  task automatic pulse_start();
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
  endtask

  task automatic run_case(input string name, input int init_tap, input int offset,
                          input bit zmode, input bit extra_start);
    int bs, bl, tgt, cyc, exp_slips, exp_post, exp_tap;
    bit win_ok, exp_err;
    logic [31:0] exp_map;
    @(negedge sys_clk); #1;
    tap = init_tap; off = offset; zero_mode = zmode;
    clear_env();
    model(bs, bl);
    win_ok  = (bl >= 4);
    tgt     = bs + (bl - 1) / 2;
    exp_err = !win_ok || zmode;
    exp_slips = !win_ok ? 0 : (zmode ? 7 : offset);
    exp_post  = win_ok ? 31 - tgt : 0;
    exp_tap   = win_ok ? tgt : 31;
    if (win_ok) exp_locked = tgt;
    exp_map = '0;
    for (int t = 0; t < 32; t++) exp_map[t] = good[t];

    pulse_start();
    if (extra_start) begin
      repeat (1000) @(negedge sys_clk);
      check({name, "_busy_mid"}, busy, 1);
      pulse_start();
    end
    cyc = 0;
    #1;
    while (!(done || error) && cyc < 40000) begin
      @(negedge sys_clk); #1;
      cyc++;
    end
    check({name, "_timeout"}, cyc < 40000, 1);
    check({name, "_done"},  done,  !exp_err);
    check({name, "_error"}, error, exp_err);
    check({name, "_busy"},  busy,  0);
    check({name, "_dec_pre"},  n_dec_pre, init_tap);
    check({name, "_dec_mid"},  n_dec_mid, 0);
    check({name, "_inc"},      n_inc, 31);
    check({name, "_dec_post"}, n_dec_post, exp_post);
    check({name, "_bitslips"}, n_slip, exp_slips);
    check({name, "_slip_cnt"}, slip_count, exp_slips);
    check({name, "_locked"},   locked_tap, exp_locked);
    check({name, "_tap"},      tap, exp_tap);
    check({name, "_overlap"},  n_overlap, 0);
`ifdef ISERDES_ALIGN_EYE_MAP_EN
    check({name, "_eye_map"},  eye_map, exp_map);
`endif
  endtask

  initial begin
    int cyc, nwin, lo;
    clear_eye();
    clear_env();
    #1;
    check("rst_outs", {busy, done, error, id_inc, id_dec, bitslip, locked_tap, slip_count}, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk); #1;
    check("idle_outs", {busy, done, error, id_inc, id_dec, bitslip, locked_tap, slip_count}, 0);
`ifdef ISERDES_ALIGN_EYE_MAP_EN
    check("rst_eye_map", eye_map, 0);
`endif

    clear_eye(); set_eye(10, 20);
    run_case("eye10_20", 7, 3, 0, 0);

    clear_eye(); set_eye(2, 5); set_eye(20, 27);
    run_case("two_win", $urandom_range(0, 31), $urandom_range(0, 7), 0, 1);

    clear_eye(); set_eye(4, 9); set_eye(20, 25);
    run_case("tie", $urandom_range(0, 31), $urandom_range(0, 7), 0, 0);

    clear_eye();
    run_case("no_eye", $urandom_range(0, 31), 0, 0, 0);

    clear_eye(); set_eye(10, 20);
    run_case("no_pattern", $urandom_range(0, 31), 0, 1, 0);

    // Reset mid-scan at tap 12.
    clear_eye(); set_eye(10, 20);
    @(negedge sys_clk); #1;
    tap = 5; off = 2; zero_mode = 0;
    clear_env();
    pulse_start();
    cyc = 0;
    while (!(seen_inc && tap == 12) && cyc < 20000) begin
      @(negedge sys_clk); cyc++;
    end
    check("mid_reach_tap12", cyc < 20000, 1);
    repeat (20) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    check("mid_rst_outs", {busy, done, error, id_inc, id_dec, bitslip, locked_tap, slip_count}, 0);
`ifdef ISERDES_ALIGN_EYE_MAP_EN
    check("mid_rst_eye_map", eye_map, 0);
`endif
    exp_locked = 0;
    clear_env();
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (100) @(negedge sys_clk); #1;
    check("mid_rst_pulses", n_inc + n_dec_pre + n_dec_mid + n_dec_post + n_slip, 0);
    check("mid_rst_tap_kept", tap, 12);
    check("mid_rst_busy", busy, 0);
    run_case("after_rst", 12, 2, 0, 0);

    // Randomized eyes, offsets and starting taps.
    for (int r = 0; r < 4; r++) begin
      clear_eye();
      nwin = $urandom_range(1, 3);
      for (int w = 0; w < nwin; w++) begin
        lo = $urandom_range(0, 31);
        set_eye(lo, lo + $urandom_range(0, 11));
      end
      run_case($sformatf("rand%0d", r), $urandom_range(0, 31), $urandom_range(0, 7), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
